// File: rtl/fetch_pc_pkg.sv
// Shared e5rv32 definitions used by the fetch stage: XLEN, default vectors,
// fetch state encoding and the execute-stage jump encodings.
package e5rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0004;
    localparam logic [XLEN-1:0] PC_STEP              = 32'd4;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        PEND  = 2'b10
    } fetch_state_e;

    // Jump kinds decided in execute; fetch only sees the resulting PCJmpE.
    typedef enum logic [1:0] {
        DESACTIVAR = 2'b00,
        BRANCH     = 2'b01,
        JAL        = 2'b10,
        JALR       = 2'b11
    } jmp_e;

    function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_pc_if.sv
// Instruction-memory handshake between the fetch unit (master) and imem (slave).
interface fetch_pc_if;
    import e5rv32_pkg::*;

    logic            ImemReq;
    logic            ImemReady;
    logic [XLEN-1:0] PCF;

    modport master (
        output ImemReq,
        output PCF,
        input  ImemReady
    );

    modport slave (
        input  ImemReq,
        input  PCF,
        output ImemReady
    );

endinterface

// File: rtl/fetch_pc.sv
// e5rv32 fetch PC unit: owns PCF, handshakes with imem, holds redirects that
// arrive mid-fetch and flushes wrong-path work. Misalign trap: FETCH_MISALIGN_TRAP_EN.
module fetch_pc
    import e5rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCJmpE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallF,
    fetch_pc_if.master      imem,
    output logic [XLEN-1:0] PCPlus4F,
    output logic            FlushD,
    output logic            FlushE
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            MisalignE
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] jmp_pc;
    logic [XLEN-1:0] pend_pc;
    logic            imem_req;
    logic            flush_d;
    logic            flush_e;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic unused_tgt_bit0;

    assign tgt             = {PCTargetE[XLEN-1:1], 1'b0};
    assign unused_tgt_bit0 = PCTargetE[0];
    // A halfword-aligned target diverts to the trap handler instead of being taken.
    assign jmp_pc          = tgt[1] ? TRAP_VECTOR : tgt;
    assign pend_pc         = pend_tgt_q[1] ? TRAP_VECTOR : pend_tgt_q;
    assign MisalignE       = PCJmpE & tgt[1] & (state_q != BOOT);
`else
    logic [1:0]      unused_tgt_bits;
    logic [XLEN-1:0] unused_trap_vector;

    assign tgt                = {PCTargetE[XLEN-1:2], 2'b00};
    assign unused_tgt_bits    = PCTargetE[1:0];
    assign unused_trap_vector = TRAP_VECTOR;
    assign jmp_pc             = tgt;
    assign pend_pc            = pend_tgt_q;
`endif

    assign PCPlus4F       = next_seq_pc(pcf_q);
    assign imem.PCF       = pcf_q;
    assign imem.ImemReq   = imem_req;
    assign FlushD         = flush_d;
    assign FlushE         = flush_e;

    always_comb begin
        state_d    = state_q;
        pcf_d      = pcf_q;
        pend_tgt_d = pend_tgt_q;
        imem_req   = 1'b1;
        flush_d    = PCJmpE;
        flush_e    = PCJmpE;

        unique case (state_q)
            BOOT: begin
                imem_req = 1'b0;
                flush_d  = 1'b1;
                flush_e  = 1'b1;
                state_d  = FETCH;
            end

            FETCH: begin
                if (PCJmpE) begin
                    if (imem.ImemReady) begin
                        pcf_d = jmp_pc;
                    end else begin
                        pend_tgt_d = tgt;
                        state_d    = PEND;
                    end
                end else if (imem.ImemReady && !StallF) begin
                    pcf_d = PCPlus4F;
                end
            end

            // Memory cannot abort, so the old PCF stays requested until it returns.
            PEND: begin
                if (PCJmpE) begin
                    pend_tgt_d = tgt;
                end
                if (imem.ImemReady) begin
                    pcf_d   = PCJmpE ? jmp_pc : pend_pc;
                    flush_d = 1'b1;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pcf_q      <= RESET_VECTOR;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pcf_q      <= pcf_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc: a cycle-level reference model compared every
// cycle, plus directed vectors with literal PCF/flush expectations.
`timescale 1ns/1ps
module tb_fetch_pc;
    import e5rv32_pkg::*;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0004;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        PCJmpE    = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic        StallF    = 1'b0;
    logic [31:0] PCPlus4F;
    logic        FlushD;
    logic        FlushE;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        MisalignE;
`endif

    int n_vectors     = 0;
    int n_miscompares = 0;

    fetch_pc_if imem();

    fetch_pc #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PCJmpE    (PCJmpE),
        .PCTargetE (PCTargetE),
        .StallF    (StallF),
        .imem      (imem.master),
        .PCPlus4F  (PCPlus4F),
        .FlushD    (FlushD),
`ifdef FETCH_MISALIGN_TRAP_EN
        .FlushE    (FlushE),
        .MisalignE (MisalignE)
`else
        .FlushE    (FlushE)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, return at the falling edge.
    task automatic applyStimulus(input logic jmp, input logic [31:0] target, input logic stall, input logic ready);
        @(posedge clk);
        #1;
        PCJmpE          = jmp;
        PCTargetE       = target;
        StallF          = stall;
        imem.ImemReady  = ready;
        @(negedge clk);
    endtask

    task automatic releaseReset(input logic ready);
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        PCJmpE         = 1'b0;
        PCTargetE      = 32'h0;
        StallF         = 1'b0;
        imem.ImemReady = ready;
        @(negedge clk);
    endtask

    // Reference model: where fetch is, whether a redirect is parked, and what it resolves to.
    logic        m_boot = 1'b1;
    logic [31:0] m_pc = RV;
    logic        m_pend = 1'b0;
    logic [31:0] m_pend_addr = 32'h0;
    logic        n_boot = 1'b1;
    logic [31:0] n_pc = RV;
    logic        n_pend = 1'b0;
    logic [31:0] n_pend_addr = 32'h0;

    function automatic logic [31:0] modelTarget(input logic [31:0] raw);
`ifdef FETCH_MISALIGN_TRAP_EN
        logic [31:0] t;
        t = raw & ~32'h1;
        return (t[1] == 1'b1) ? TV : t;
`else
        return raw & ~32'h3;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_boot = 1'b1;
            m_pc   = RV;
            m_pend = 1'b0;
        end
        checkOutput("ImemReq",  32'(imem.ImemReq), 32'(!m_boot));
        checkOutput("PCF",      imem.PCF, m_pc);
        checkOutput("PCPlus4F", PCPlus4F, m_pc + 32'd4);
        checkOutput("FlushD",   32'(FlushD), 32'(m_boot || PCJmpE || (m_pend && imem.ImemReady)));
        checkOutput("FlushE",   32'(FlushE), 32'(m_boot || PCJmpE));
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("MisalignE", 32'(MisalignE), 32'(!m_boot && PCJmpE && PCTargetE[1]));
`endif
        n_boot      = 1'b0;
        n_pc        = m_pc;
        n_pend      = m_pend;
        n_pend_addr = m_pend_addr;
        if (m_boot) begin
            n_boot = 1'b0;
        end else if (PCJmpE) begin
            if (imem.ImemReady) begin
                n_pc   = modelTarget(PCTargetE);
                n_pend = 1'b0;
            end else begin
                n_pend      = 1'b1;
                n_pend_addr = modelTarget(PCTargetE);
            end
        end else if (m_pend) begin
            if (imem.ImemReady) begin
                n_pc   = m_pend_addr;
                n_pend = 1'b0;
            end
        end else if (imem.ImemReady && !StallF) begin
            n_pc = m_pc + 32'd4;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            m_boot      = n_boot;
            m_pc        = n_pc;
            m_pend      = n_pend;
            m_pend_addr = n_pend_addr;
        end
    end

    initial begin
        imem.ImemReady = 1'b0;
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset PCF", imem.PCF, 32'h0);
        checkOutput("reset ImemReq", 32'(imem.ImemReq), 32'h0);
        checkOutput("reset PCPlus4F", PCPlus4F, 32'h4);
        @(negedge clk);

        releaseReset(1'b1);
        checkOutput("boot ImemReq", 32'(imem.ImemReq), 32'h0);
        checkOutput("boot FlushD", 32'(FlushD), 32'h1);

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("seq PCF0", imem.PCF, 32'h0);
        checkOutput("seq ImemReq", 32'(imem.ImemReq), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("seq PCF4", imem.PCF, 32'h4);

        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("stall PCF8 a", imem.PCF, 32'h8);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("stall PCF8 b", imem.PCF, 32'h8);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("stall PCF8 c", imem.PCF, 32'h8);

        applyStimulus(1'b1, 32'h101, 1'b0, 1'b1);
        checkOutput("seq PCFC", imem.PCF, 32'hC);
        checkOutput("jmp FlushD", 32'(FlushD), 32'h1);
        checkOutput("jmp FlushE", 32'(FlushE), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("jmp PCF", imem.PCF, 32'h100);
        checkOutput("jmp PCPlus4F", PCPlus4F, 32'h104);

        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
        checkOutput("busy PCF", imem.PCF, 32'h104);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("pend ImemReq", 32'(imem.ImemReq), 32'h1);
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0);
        checkOutput("pend PCF", imem.PCF, 32'h104);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("pend exit FlushD", 32'(FlushD), 32'h1);
        checkOutput("pend exit FlushE", 32'(FlushE), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("youngest wins PCF", imem.PCF, 32'h300);

        applyStimulus(1'b1, 32'h40, 1'b1, 1'b1);
        checkOutput("jmp+stall PCF", imem.PCF, 32'h304);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("jmp over stall PCF", imem.PCF, 32'h40);

        applyStimulus(1'b1, 32'h22, 1'b0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("misalign pulse", 32'(MisalignE), 32'h1);
`endif
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("misalign PCF", imem.PCF, 32'h4);
        checkOutput("misalign pulse end", 32'(MisalignE), 32'h0);
`else
        checkOutput("misalign PCF", imem.PCF, 32'h20);
`endif

        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("wrap PCF", imem.PCF, 32'hFFFF_FFFC);
        checkOutput("wrap PCPlus4F", PCPlus4F, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("wrapped PCF", imem.PCF, 32'h0);

        applyStimulus(1'b1, 32'h500, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("pre-reset PCF", imem.PCF, 32'h4);
        #2;
        rst_n          = 1'b0;
        imem.ImemReady = 1'b1;
        #1;
        checkOutput("async reset PCF", imem.PCF, 32'h0);
        checkOutput("async reset ImemReq", 32'(imem.ImemReq), 32'h0);
        @(negedge clk);
        @(negedge clk);
        releaseReset(1'b1);
        checkOutput("reboot PCF", imem.PCF, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("reboot fetch PCF", imem.PCF, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("no stale redirect PCF", imem.PCF, 32'h4);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("no stale redirect PCF 2", imem.PCF, 32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
